reel_select_sequencer: RTL and testbench

Multi-channel, parametrised successor to the single-channel 60 Hz select toggler.
- A shared prescaler derives a tick strobe from clk.
- Each channel (one per slot reel) runs a modulo select counter. It advances every (div+1) ticks and wraps at SEL_MAX.
- Each channel has start/stop control and a stop-complete handshake.
- Feeds reel symbol select logic and game-control FSM.

---
 rtl/reel_select_sequencer.sv | 125 ++++++++++++
 tb/tb_reel_select_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/reel_select_sequencer.sv
// Multi-channel reel select sequencer: a shared prescaler tick drives per-channel
// modulo select counters, each with start/stop control and a stop-complete pulse.
module reel_select_sequencer #(
  parameter int NUM_CH   = 3,
  parameter int SEL_W    = 3,
  parameter int SEL_MAX  = 4,
  parameter int PRESCALE = 2000000,
  parameter int DIV_W    = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [NUM_CH-1:0]         stop_req,
  input  logic [NUM_CH*DIV_W-1:0]   div,
  output logic [NUM_CH*SEL_W-1:0]   sel,
  output logic [NUM_CH-1:0]         running,
  output logic [NUM_CH-1:0]         stopped_pulse,
  output logic                      tick
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PRESCALE - 1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(SEL_MAX);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_STOPPING
  } state_t;

  logic [PS_W-1:0] presc_q;
  logic [PS_W-1:0] presc_d;
  logic            tick_q;

  always_comb begin
    presc_d = (presc_q == PS_LAST) ? '0 : presc_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      tick_q  <= (presc_q == PS_LAST);
    end
  end

  assign tick = tick_q;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    state_t            state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [DIV_W-1:0]  div_ch;
    logic              step;
    logic              run_q;
    logic              pulse_q, pulse_d;

    assign div_ch = div[gi*DIV_W +: DIV_W];
    // >= rather than == so a lowered divider takes effect on the next tick
    assign step   = tick_q && (cnt_q >= div_ch);

    always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      cnt_d   = cnt_q;
      pulse_d = 1'b0;

      if ((state_q != ST_IDLE) && tick_q) begin
        if (step) begin
          cnt_d = '0;
          sel_d = (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      case (state_q)
        ST_IDLE: begin
          cnt_d = '0;
          if (start) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (stop_req[gi]) begin
            if (step) begin
              state_d = ST_IDLE;
              pulse_d = 1'b1;
            end else begin
              state_d = ST_STOPPING;
            end
          end
        end
        ST_STOPPING: begin
          if (step) begin
            state_d = ST_IDLE;
            pulse_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        state_q <= ST_IDLE;
        sel_q   <= '0;
        cnt_q   <= '0;
        run_q   <= 1'b0;
        pulse_q <= 1'b0;
      end else begin
        state_q <= state_d;
        sel_q   <= sel_d;
        cnt_q   <= cnt_d;
        run_q   <= (state_d != ST_IDLE);
        pulse_q <= pulse_d;
      end
    end

    assign sel[gi*SEL_W +: SEL_W] = sel_q;
    assign running[gi]            = run_q;
    assign stopped_pulse[gi]      = pulse_q;
  end

endmodule

// File: tb/tb_reel_select_sequencer.sv
// Scoreboard bench for reel_select_sequencer with PRESCALE=4: stimulus queues the
// hand-computed state after each tick, a monitor pops and compares it.
module tb_reel_select_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  stop_req;
  logic [11:0] div;
  logic [8:0]  sel;
  logic [2:0]  running;
  logic [2:0]  stopped_pulse;
  logic        tick;

  reel_select_sequencer #(
    .NUM_CH(3), .SEL_W(3), .SEL_MAX(4), .PRESCALE(4), .DIV_W(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .stop_req(stop_req),
    .div(div),
    .sel(sel),
    .running(running),
    .stopped_pulse(stopped_pulse),
    .tick(tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] sel;
    logic [2:0] run;
    logic [2:0] pulse;
    int         id;
  } exp_t;

  exp_t exp_q[$];
  int   vec_cnt;
  int   miss_cnt;
  int   tick_id;
  bit   post_tick;

  function automatic logic [8:0] pk(input int s0, input int s1, input int s2);
    return {3'(s2), 3'(s1), 3'(s0)};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    vec_cnt++;
    if (got !== want) begin
      miss_cnt++;
      $display("FAIL %s: got %0h, required %0h", name, got, want);
    end
  endtask

  // Monitor: the cycle after each tick carries the updated channel state
  initial begin
    exp_t e;
    post_tick = 1'b0;
    forever begin
      @(negedge clk);
      if (post_tick) begin
        vec_cnt++;
        if (exp_q.size() == 0) begin
          miss_cnt++;
          $display("FAIL unexpected_tick: got sel=%h running=%b pulse=%b, required no tick", sel, running, stopped_pulse);
        end else begin
          e = exp_q.pop_front();
          if ({sel, running, stopped_pulse} !== {e.sel, e.run, e.pulse}) begin
            miss_cnt++;
            $display("FAIL tick%0d: got sel=%h running=%b pulse=%b, required sel=%h running=%b pulse=%b",
                     e.id, sel, running, stopped_pulse, e.sel, e.run, e.pulse);
          end else begin
            $display("tick%0d ok: sel=%h running=%b pulse=%b", e.id, sel, running, stopped_pulse);
          end
        end
      end else if (stopped_pulse !== 3'b000) begin
        vec_cnt++;
        miss_cnt++;
        $display("FAIL stray_pulse: got %b, required 000", stopped_pulse);
      end
      post_tick = (tick === 1'b1);
    end
  end

  task automatic wait_tick();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n > 16) begin
        $display("FAIL tick_timeout: got no tick in 16 cycles, required one every 4");
        $fatal(1, "tick timeout");
      end
    end while (tick !== 1'b1);
  endtask

  task automatic tick_step(input int s0, input int s1, input int s2,
                           input logic [2:0] run, input logic [2:0] pulse, input logic [2:0] stop);
    exp_t e;
    wait_tick();
    stop_req = stop;
    e.sel = pk(s0, s1, s2);
    e.run = run;
    e.pulse = pulse;
    e.id = tick_id;
    tick_id++;
    exp_q.push_back(e);
    @(negedge clk);
    stop_req = 3'b000;
  endtask

  task automatic mid(input logic st, input logic [2:0] stop);
    @(negedge clk);
    start = st;
    stop_req = stop;
    @(negedge clk);
    start = 1'b0;
    stop_req = 3'b000;
  endtask

  task automatic reset_release();
    exp_t e;
    reset = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk($sformatf("tick_after_release_c%0d", i), 32'(tick), (i == 4) ? 32'd1 : 32'd0);
    end
    e.sel = 9'd0;
    e.run = 3'b000;
    e.pulse = 3'b000;
    e.id = tick_id;
    tick_id++;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_sel"}, 32'(sel), 32'd0);
    chk({tag, "_running"}, 32'(running), 32'd0);
    chk({tag, "_pulse"}, 32'(stopped_pulse), 32'd0);
    chk({tag, "_tick"}, 32'(tick), 32'd0);
  endtask

  initial begin
    vec_cnt = 0;
    miss_cnt = 0;
    tick_id = 0;
    reset = 1'b1;
    start = 1'b0;
    stop_req = 3'b000;
    div = 12'd0;
    repeat (3) @(negedge clk);
    chk_reset_state("reset0");
    reset_release();

    // all div=0: every tick steps, wrap after 4
    mid(1'b1, 3'b000);
    tick_step(1, 1, 1, 3'b111, 3'b000, 3'b000);
    tick_step(2, 2, 2, 3'b111, 3'b000, 3'b000);
    tick_step(3, 3, 3, 3'b111, 3'b000, 3'b000);
    tick_step(4, 4, 4, 3'b111, 3'b000, 3'b000);
    tick_step(0, 0, 0, 3'b111, 3'b000, 3'b000);
    tick_step(1, 1, 1, 3'b111, 3'b000, 3'b000);
    tick_step(2, 2, 2, 3'b000, 3'b111, 3'b111);
    tick_step(2, 2, 2, 3'b000, 3'b000, 3'b000);

    // mixed dividers from reset: ch0=0, ch1=1, ch2=3
    reset = 1'b1;
    div = {4'd3, 4'd1, 4'd0};
    repeat (2) @(negedge clk);
    chk_reset_state("reset1");
    reset_release();
    mid(1'b1, 3'b000);
    tick_step(1, 0, 0, 3'b111, 3'b000, 3'b000);
    tick_step(2, 1, 0, 3'b111, 3'b000, 3'b000);
    tick_step(3, 1, 0, 3'b111, 3'b000, 3'b000);
    tick_step(4, 2, 1, 3'b111, 3'b000, 3'b000);
    tick_step(0, 2, 1, 3'b111, 3'b000, 3'b000);
    tick_step(1, 3, 1, 3'b111, 3'b000, 3'b000);
    tick_step(2, 3, 1, 3'b111, 3'b000, 3'b000);
    tick_step(3, 4, 2, 3'b111, 3'b000, 3'b000);

    // ch1 stop two cycles after its step: one more advance then idle
    mid(1'b0, 3'b010);
    chk("running_stopping", 32'(running), 32'b111);
    tick_step(4, 4, 2, 3'b111, 3'b000, 3'b000);
    tick_step(0, 0, 2, 3'b101, 3'b010, 3'b000);
    tick_step(1, 0, 2, 3'b101, 3'b000, 3'b000);
    // ch0 stop on its own step cycle
    tick_step(2, 0, 3, 3'b100, 3'b001, 3'b001);
    mid(1'b0, 3'b011);
    tick_step(2, 0, 3, 3'b100, 3'b000, 3'b000);

    // resume from held values; second start while running is ignored
    mid(1'b1, 3'b000);
    tick_step(3, 0, 3, 3'b111, 3'b000, 3'b000);
    mid(1'b1, 3'b000);
    tick_step(4, 1, 3, 3'b111, 3'b000, 3'b000);
    tick_step(0, 1, 4, 3'b111, 3'b000, 3'b000);
    tick_step(1, 2, 4, 3'b111, 3'b000, 3'b000);
    tick_step(2, 2, 4, 3'b111, 3'b000, 3'b000);
    tick_step(3, 3, 4, 3'b111, 3'b000, 3'b000);

    // reset while ch1 is stopping at sel=3
    mid(1'b0, 3'b010);
    chk("running_stopping2", 32'(running), 32'b111);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_state("reset2");
    reset_release();
    tick_step(0, 0, 0, 3'b000, 3'b000, 3'b000);

    repeat (2) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
